// File: rtl/led_shifter_if.sv
// Board-side pin bundle for the LED shifter: buttons, switches, mode in; LEDs, count out.
// master = board/driver side, slave = led_shifter.
interface led_shifter_if #(
  parameter int WIDTH = 8
);
  logic             leftbutt;
  logic             rightbutt;
  logic             leftswitch;
  logic             rightswitch;
  logic [1:0]       mode;
  logic [WIDTH-1:0] led;
  logic [7:0]       shift_count;

  modport master (
    output leftbutt, rightbutt,
    output leftswitch, rightswitch,
    output mode,
    input  led, shift_count
  );

  modport slave (
    input  leftbutt, rightbutt,
    input  leftswitch, rightswitch,
    input  mode,
    output led, shift_count
  );
endinterface

// File: rtl/led_shifter.sv
// Button-driven WIDTH-bit shift register with sync, debounce and shift modes.
// Ports: clk, reset (async active-low), io (slave: buttons/switches/mode in, led/shift_count out).
module led_shifter #(
  parameter int WIDTH             = 8,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int SYNC_STAGES       = 2,
  parameter int BUTTON_ACTIVE_LOW = 0
) (
  input logic     clk,
  input logic     reset,
  led_shifter_if.slave io
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  // bit 0 left button, 1 right button, 2 left switch, 3 right switch
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]       raw;
  logic [3:0]       synced;
  logic [1:0]       s;

  logic [1:0]       stable_q;
  logic [1:0]       prev_q;
  logic [1:0]       pulse_q;
  logic [CW-1:0]    db_cnt_q [2];

  logic [WIDTH-1:0] led_q, led_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] lv, rv;
  logic             go_l, go_r, hold;

  assign raw    = {io.rightswitch, io.leftswitch,
                   io.rightbutt, io.leftbutt};
  assign synced = sync_q[SYNC_STAGES-1];
  assign s      = (BUTTON_ACTIVE_LOW != 0) ? ~synced[1:0]
                                           : synced[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Debounce: a level change must hold DEBOUNCE_CYCLES cycles.
  // The pulse is taken from the accepted level one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CMAX) begin
          stable_q[i] <= s[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
      prev_q  <= stable_q;
      pulse_q <= stable_q & ~prev_q;
    end
  end

  // A coincident left+right pulse is a collision and is dropped.
  assign go_l = pulse_q[0] & ~pulse_q[1];
  assign go_r = pulse_q[1] & ~pulse_q[0];

  always_comb begin
    lv   = led_q;
    rv   = led_q;
    hold = 1'b0;
    unique case (io.mode)
      2'b00: begin
        lv = {led_q[WIDTH-2:0], synced[2]};
        rv = {synced[3], led_q[WIDTH-1:1]};
      end
      2'b01: begin
        lv = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        rv = {led_q[0], led_q[WIDTH-1:1]};
      end
      2'b10: begin
        lv = {led_q[WIDTH-2:0], 1'b0};
        rv = {led_q[WIDTH-1], led_q[WIDTH-1:1]};
      end
      2'b11: hold = 1'b1;
      default: hold = 1'b1;
    endcase
  end

  always_comb begin
    led_d = led_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      go_l && !hold: begin
        led_d = lv;
        cnt_d = cnt_q + 8'd1;
      end
      go_r && !hold: begin
        led_d = rv;
        cnt_d = cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
      cnt_q <= '0;
    end else begin
      led_q <= led_d;
      cnt_q <= cnt_d;
    end
  end

  assign io.led         = led_q;
  assign io.shift_count = cnt_q;

endmodule

// File: tb/tb_led_shifter.sv
// Self-checking bench for led_shifter (WIDTH=8, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Random and directed button presses checked against an arithmetic model.
module tb_led_shifter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   exp_led;
  int   exp_cnt;

  led_shifter_if #(.WIDTH(8)) bus ();

  led_shifter #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2),
    .BUTTON_ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected effect of one accepted press, from the shift rules.
  function automatic void apply(input bit l, input bit r,
                                input int m, input bit lsw,
                                input bit rsw);
    int v;
    if (l == r) return;
    if (m == 3) return;
    v = exp_led;
    case (m)
      0: v = l ? ((v * 2) % 256 + lsw) : (v / 2 + rsw * 128);
      1: v = l ? ((v * 2) % 256 + v / 128) : (v / 2 + (v % 2) * 128);
      default: v = l ? ((v * 2) % 256) : (v / 2 + (v / 128) * 128);
    endcase
    exp_led = v;
    exp_cnt = (exp_cnt + 1) % 256;
  endfunction

  task automatic press(input bit l, input bit r);
    @(negedge clk);
    bus.leftbutt  = l;
    bus.rightbutt = r;
    repeat (10) @(negedge clk);
    bus.leftbutt  = 1'b0;
    bus.rightbutt = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] val);
    bus.mode = 2'b00;
    for (int i = 7; i >= 0; i--) begin
      bus.leftswitch = val[i];
      press(1'b1, 1'b0);
      apply(1'b1, 1'b0, 0, val[i], 1'b0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.leftbutt = 0; bus.rightbutt = 0;
    bus.leftswitch = 0; bus.rightswitch = 0;
    bus.mode = 2'b00;
    exp_led = 0; exp_cnt = 0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.led !== 8'h00 || bus.shift_count !== 8'h00) begin
      bad++;
      $display("FAIL reset: led=%h cnt=%0d want 00/0",
               bus.led, bus.shift_count);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill;
    bus.mode = 2'b00;
    bus.leftswitch = 1'b1;
    @(negedge clk);
    bus.leftbutt = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 6) begin
        total++;
        if (bus.led !== 8'h00) begin
          bad++;
          $display("FAIL fill_early: led=%h at edge 6 want 00", bus.led);
        end
      end
      if (e == 7) begin
        total++;
        if (bus.led !== 8'h01) begin
          bad++;
          $display("FAIL fill_latency: led=%h at edge 7 want 01", bus.led);
        end
      end
    end
    repeat (2) @(negedge clk);
    bus.leftbutt = 1'b0;
    repeat (10) @(negedge clk);
    apply(1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      press(1'b1, 1'b0);
      apply(1'b1, 1'b0, 0, 1'b1, 1'b0);
    end
    total++;
    if (bus.led !== 8'h07 || bus.shift_count !== 8'd3) begin
      bad++;
      $display("FAIL fill: led=%h cnt=%0d want 07/3",
               bus.led, bus.shift_count);
    end
  endtask

  task automatic test_bounce;
    bus.mode = 2'b00;
    bus.leftswitch = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.leftbutt = ((c / 2) % 2) == 0;
      total++;
      if (bus.led !== exp_led[7:0] || bus.shift_count !== exp_cnt[7:0]) begin
        bad++;
        $display("FAIL bounce_quiet: led=%h cnt=%0d want %h/%0d",
                 bus.led, bus.shift_count, exp_led[7:0], exp_cnt);
      end
    end
    @(negedge clk);
    bus.leftbutt = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 6) begin
        total++;
        if (bus.led !== exp_led[7:0]) begin
          bad++;
          $display("FAIL bounce_early: led=%h want %h",
                   bus.led, exp_led[7:0]);
        end
      end
    end
    apply(1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    total++;
    if (bus.led !== exp_led[7:0] || bus.shift_count !== exp_cnt[7:0]) begin
      bad++;
      $display("FAIL bounce_once: led=%h cnt=%0d want %h/%0d",
               bus.led, bus.shift_count, exp_led[7:0], exp_cnt);
    end
    bus.leftbutt = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_rotate;
    load(8'h81);
    total++;
    if (bus.led !== 8'h81) begin
      bad++;
      $display("FAIL rot_load: led=%h want 81", bus.led);
    end
    bus.mode = 2'b01;
    bus.leftswitch = 1'b1;
    bus.rightswitch = 1'b1;
    press(1'b0, 1'b1);
    apply(1'b0, 1'b1, 1, 1'b1, 1'b1);
    total++;
    if (bus.led !== exp_led[7:0]) begin
      bad++;
      $display("FAIL rot_right: led=%h want %h", bus.led, exp_led[7:0]);
    end
    for (int k = 0; k < 2; k++) begin
      press(1'b1, 1'b0);
      apply(1'b1, 1'b0, 1, 1'b1, 1'b1);
      total++;
      if (bus.led !== exp_led[7:0]) begin
        bad++;
        $display("FAIL rot_left%0d: led=%h want %h",
                 k, bus.led, exp_led[7:0]);
      end
    end
  endtask

  task automatic test_arith;
    load(8'h80);
    bus.mode = 2'b10;
    bus.leftswitch = 1'b1;
    bus.rightswitch = 1'b0;
    for (int k = 0; k < 2; k++) begin
      press(1'b0, 1'b1);
      apply(1'b0, 1'b1, 2, 1'b1, 1'b0);
      total++;
      if (bus.led !== exp_led[7:0]) begin
        bad++;
        $display("FAIL arith_right%0d: led=%h want %h",
                 k, bus.led, exp_led[7:0]);
      end
    end
    press(1'b1, 1'b0);
    apply(1'b1, 1'b0, 2, 1'b1, 1'b0);
    total++;
    if (bus.led !== exp_led[7:0] || bus.shift_count !== exp_cnt[7:0]) begin
      bad++;
      $display("FAIL arith_left: led=%h cnt=%0d want %h/%0d",
               bus.led, bus.shift_count, exp_led[7:0], exp_cnt);
    end
  endtask

  task automatic test_hold_collision;
    bus.mode = 2'b11;
    press(1'b1, 1'b0);
    total++;
    if (bus.led !== exp_led[7:0] || bus.shift_count !== exp_cnt[7:0]) begin
      bad++;
      $display("FAIL hold: led=%h cnt=%0d want %h/%0d",
               bus.led, bus.shift_count, exp_led[7:0], exp_cnt);
    end
    bus.mode = 2'b00;
    repeat (10) @(negedge clk);
    total++;
    if (bus.led !== exp_led[7:0] || bus.shift_count !== exp_cnt[7:0]) begin
      bad++;
      $display("FAIL hold_queued: led=%h cnt=%0d want %h/%0d",
               bus.led, bus.shift_count, exp_led[7:0], exp_cnt);
    end
    press(1'b1, 1'b1);
    total++;
    if (bus.led !== exp_led[7:0] || bus.shift_count !== exp_cnt[7:0]) begin
      bad++;
      $display("FAIL collision: led=%h cnt=%0d want %h/%0d",
               bus.led, bus.shift_count, exp_led[7:0], exp_cnt);
    end
  endtask

  task automatic test_random;
    int m, pick;
    bit l, r, lsw, rsw;
    for (int k = 0; k < 24; k++) begin
      m    = $urandom_range(0, 3);
      pick = $urandom_range(0, 4);
      l    = (pick != 1);
      r    = (pick == 1) || (pick == 4);
      lsw  = $urandom_range(0, 1);
      rsw  = $urandom_range(0, 1);
      bus.mode        = m[1:0];
      bus.leftswitch  = lsw;
      bus.rightswitch = rsw;
      press(l, r);
      apply(l, r, m, lsw, rsw);
      total++;
      if (bus.led !== exp_led[7:0] || bus.shift_count !== exp_cnt[7:0]) begin
        bad++;
        $display("FAIL rand%0d m=%0d l=%0b r=%0b: led=%h cnt=%0d want %h/%0d",
                 k, m, l, r, bus.led, bus.shift_count,
                 exp_led[7:0], exp_cnt);
      end
    end
  endtask

  task automatic test_async_reset;
    load(8'h5A);
    total++;
    if (bus.led !== 8'h5A) begin
      bad++;
      $display("FAIL ar_load: led=%h want 5a", bus.led);
    end
    bus.mode = 2'b00;
    bus.leftswitch = 1'b1;
    @(negedge clk);
    bus.leftbutt = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.led !== 8'h00 || bus.shift_count !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: led=%h cnt=%0d want 00/0",
               bus.led, bus.shift_count);
    end
    exp_led = 0;
    exp_cnt = 0;
    #1 rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 6) begin
        total++;
        if (bus.led !== 8'h00) begin
          bad++;
          $display("FAIL ar_early: led=%h want 00", bus.led);
        end
      end
      if (e == 7) begin
        total++;
        if (bus.led !== 8'h01) begin
          bad++;
          $display("FAIL ar_latency: led=%h want 01", bus.led);
        end
      end
    end
    repeat (12) @(negedge clk);
    total++;
    if (bus.led !== 8'h01 || bus.shift_count !== 8'd1) begin
      bad++;
      $display("FAIL ar_once: led=%h cnt=%0d want 01/1",
               bus.led, bus.shift_count);
    end
    bus.leftbutt = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_bounce();
    test_rotate();
    test_arith();
    test_hold_collision();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
